// File: rtl/hb_adc_sampler.sv
// PmodAD1 dual-channel SPI sampler: periodic conversion of both 12-bit channels,
// result presented as a 32-bit word with a ready/ack handshake and sticky overrun.
module hb_adc_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 50000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        adc_cs_n,
    input  logic        adc_d0,
    input  logic        adc_d1,
    output logic        adc_sclk,
    input  logic        read_ack,
    output logic        read_rdy,
    output logic [31:0] heartbeat_data
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LATCH
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   period_cnt;
    logic            tick;
    logic [DW-1:0]   div_cnt;
    logic            div_wrap;
    logic [4:0]      bit_cnt;
    logic [11:0]     shift0, shift1;
    logic [11:0]     ch0_q, ch1_q;
    logic [3:0]      seq_q;
    logic            overrun_q;

    assign tick     = (period_cnt == PW'(SAMPLE_PERIOD - 1));
    assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = CONV;
            CONV:    if (div_wrap && !adc_sclk && bit_cnt == 5'd16) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // 12-bit shift registers: the four leading zeros of each 16-bit frame shift out the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shift0   <= '0;
            shift1   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        adc_cs_n <= 1'b0;
                        adc_sclk <= 1'b1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                CONV: begin
                    if (div_wrap) begin
                        div_cnt  <= '0;
                        adc_sclk <= ~adc_sclk;
                        if (adc_sclk) begin
                            shift0  <= {shift0[10:0], adc_d0};
                            shift1  <= {shift1[10:0], adc_d1};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (bit_cnt == 5'd16) begin
                            adc_cs_n <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // An ack coinciding with LATCH consumes the old word, so the new one is not an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_rdy  <= 1'b0;
            overrun_q <= 1'b0;
            ch0_q     <= '0;
            ch1_q     <= '0;
            seq_q     <= '0;
        end else if (state_q == LATCH) begin
            ch0_q     <= shift0;
            ch1_q     <= shift1;
            seq_q     <= seq_q + 1'b1;
            read_rdy  <= 1'b1;
            overrun_q <= read_rdy & ~read_ack;
        end else if (read_ack && read_rdy) begin
            read_rdy  <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign heartbeat_data = {overrun_q, 3'b000, ch1_q, seq_q, ch0_q};

endmodule
